// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: first-word-fall-through FIFO controller around a simple dual-port
// RAM with a one-cycle registered read; a 2-entry output stage hides the read latency.
module ram_fifo_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] count,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   RAM_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   ram_cnt_r;
  logic          rd_pend_r;
  logic [1:0]    os_cnt_r;
  logic [1:0]    os_cnt_nxt_s;
  logic [DW-1:0] os_head_r;
  logic [DW-1:0] os_tail_r;
  logic          out_valid_r;
  logic          pop_s;
  logic [2:0]    occ_s;
  logic [2:0]    occ_lim_s;

  // Handshakes, RAM port drive and the read-issue decision
  always_comb begin
    pop_s     = out_valid_r && out_ready;
    in_ready  = reset_ && (ram_cnt_r != RAM_FULL);
    ram_we    = in_valid && in_ready;
    ram_waddr = wr_ptr_r;
    ram_wdata = in_data;
    // Output-stage slots already committed; a pop this cycle frees one
    occ_s     = {1'b0, os_cnt_r} + {2'b00, rd_pend_r};
    occ_lim_s = 3'd2 + {2'b00, pop_s};
    ram_re    = (ram_cnt_r != CNT_ZERO) && (occ_s < occ_lim_s);
    ram_raddr = rd_ptr_r;
    out_valid = out_valid_r;
    out_data  = os_head_r;
    count     = {1'b0, ram_cnt_r} + {{(AW+1){1'b0}}, rd_pend_r} + {{AW{1'b0}}, os_cnt_r};
  end

  // Next output-stage occupancy from returning read data and consumer pop
  always_comb begin
    case ({rd_pend_r, pop_s})
      2'b10:   os_cnt_nxt_s = os_cnt_r + 2'd1;
      2'b01:   os_cnt_nxt_s = os_cnt_r - 2'd1;
      default: os_cnt_nxt_s = os_cnt_r;
    endcase
  end

  // Pointers, RAM occupancy and read-in-flight flag
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      ram_cnt_r <= CNT_ZERO;
      rd_pend_r <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (ram_re) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({ram_we, ram_re})
        2'b10:   ram_cnt_r <= ram_cnt_r + CNT_ONE;
        2'b01:   ram_cnt_r <= ram_cnt_r - CNT_ONE;
        default: ram_cnt_r <= ram_cnt_r;
      endcase
      rd_pend_r <= ram_re;
    end
  end

  // Output stage: returning data lands behind whatever is still held
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      os_cnt_r    <= 2'd0;
      out_valid_r <= 1'b0;
      os_head_r   <= {DW{1'b0}};
      os_tail_r   <= {DW{1'b0}};
    end else begin
      os_cnt_r    <= os_cnt_nxt_s;
      out_valid_r <= (os_cnt_nxt_s != 2'd0);
      case ({rd_pend_r, pop_s})
        2'b11: begin
          if (os_cnt_r == 2'd2) begin
            os_head_r <= os_tail_r;
            os_tail_r <= ram_rdata;
          end else begin
            os_head_r <= ram_rdata;
          end
        end
        2'b10: begin
          if (os_cnt_r == 2'd0) begin
            os_head_r <= ram_rdata;
          end else begin
            os_tail_r <= ram_rdata;
          end
        end
        2'b01:   os_head_r <= os_tail_r;
        default: os_head_r <= os_head_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed and randomized checks of ram_fifo_ctrl (AW=8 and AW=2)
// against queue-based reference models, with behavioural RAMs behind each instance.
module tb_ram_fifo_ctrl;

  logic clk;
  logic reset_;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data, a_ram_wdata, a_ram_rdata;
  logic [9:0] a_count;
  logic       a_ram_we, a_ram_re;
  logic [7:0] a_ram_waddr, a_ram_raddr;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data, b_ram_wdata, b_ram_rdata;
  logic [3:0] b_count;
  logic       b_ram_we, b_ram_re;
  logic [1:0] b_ram_waddr, b_ram_raddr;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [4];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  int a_wr_n, a_rd_n, a_stall, a_tot_wr;
  int b_wr_n, b_rd_n, b_stall, b_tot_wr, b_full_hits;

  ram_fifo_ctrl #(.AW(8), .DW(8)) u_dut_a (
    .clk(clk), .reset_(reset_),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count),
    .ram_we(a_ram_we), .ram_waddr(a_ram_waddr), .ram_wdata(a_ram_wdata),
    .ram_re(a_ram_re), .ram_raddr(a_ram_raddr), .ram_rdata(a_ram_rdata)
  );

  ram_fifo_ctrl #(.AW(2), .DW(8)) u_dut_b (
    .clk(clk), .reset_(reset_),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count),
    .ram_we(b_ram_we), .ram_waddr(b_ram_waddr), .ram_wdata(b_ram_wdata),
    .ram_re(b_ram_re), .ram_raddr(b_ram_raddr), .ram_rdata(b_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAMs
  always @(posedge clk) begin
    if (a_ram_we) mem_a[a_ram_waddr] <= a_ram_wdata;
    if (a_ram_re) a_ram_rdata <= mem_a[a_ram_raddr];
    if (b_ram_we) mem_b[b_ram_waddr] <= b_ram_wdata;
    if (b_ram_re) b_ram_rdata <= mem_b[b_ram_raddr];
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  // Reference model A: FIFO contents as a queue, RAM addresses as running counts
  initial begin
    a_wr_n = 0; a_rd_n = 0; a_stall = 0; a_tot_wr = 0;
    forever begin
      @(negedge clk);
      if (!reset_) begin
        chk_eq("a_rst_in_ready", 32'(a_in_ready), 32'd0);
        chk_eq("a_rst_ram_we", 32'(a_ram_we), 32'd0);
        chk_eq("a_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk_eq("a_rst_out_data", 32'(a_out_data), 32'd0);
        chk_eq("a_rst_count", 32'(a_count), 32'd0);
        qa.delete(); a_wr_n = 0; a_rd_n = 0; a_stall = 0;
      end else begin
        chk_eq("a_count", 32'(a_count), 32'(qa.size()));
        chk_eq("a_cap", 32'(qa.size() <= 258), 32'd1);
        chk_eq("a_we", 32'(a_ram_we), 32'(a_in_valid && a_in_ready));
        if (a_ram_we) begin
          chk_eq("a_waddr", 32'(a_ram_waddr), 32'(a_wr_n % 256));
          chk_eq("a_wdata", 32'(a_ram_wdata), 32'(a_in_data));
        end
        if (a_ram_re) begin
          chk_eq("a_raddr", 32'(a_ram_raddr), 32'(a_rd_n % 256));
          chk_eq("a_re_avail", 32'(a_rd_n < a_wr_n), 32'd1);
        end
        if (qa.size() < 256) chk_eq("a_ready_hi", 32'(a_in_ready), 32'd1);
        if (qa.size() >= 258) chk_eq("a_ready_lo", 32'(a_in_ready), 32'd0);
        if (qa.size() == 0) begin
          chk_eq("a_empty_valid", 32'(a_out_valid), 32'd0);
          chk_eq("a_empty_re", 32'(a_ram_re), 32'd0);
        end else if (a_out_valid) begin
          chk_eq("a_head", 32'(a_out_data), 32'(qa[0]));
          a_stall = 0;
        end else begin
          a_stall++;
          chk_eq("a_stall", 32'(a_stall <= 2), 32'd1);
        end
        if (a_out_valid && a_out_ready && qa.size() > 0) void'(qa.pop_front());
        if (a_in_valid && a_in_ready) begin
          qa.push_back(a_in_data); a_wr_n++; a_tot_wr++;
        end
        if (a_ram_re) a_rd_n++;
      end
    end
  end

  // Reference model B (AW=2, capacity 6)
  initial begin
    b_wr_n = 0; b_rd_n = 0; b_stall = 0; b_tot_wr = 0; b_full_hits = 0;
    forever begin
      @(negedge clk);
      if (!reset_) begin
        chk_eq("b_rst_in_ready", 32'(b_in_ready), 32'd0);
        chk_eq("b_rst_out_valid", 32'(b_out_valid), 32'd0);
        chk_eq("b_rst_count", 32'(b_count), 32'd0);
        qb.delete(); b_wr_n = 0; b_rd_n = 0; b_stall = 0;
      end else begin
        chk_eq("b_count", 32'(b_count), 32'(qb.size()));
        chk_eq("b_cap", 32'(qb.size() <= 6), 32'd1);
        chk_eq("b_we", 32'(b_ram_we), 32'(b_in_valid && b_in_ready));
        if (b_ram_we) chk_eq("b_waddr", 32'(b_ram_waddr), 32'(b_wr_n % 4));
        if (b_ram_re) begin
          chk_eq("b_raddr", 32'(b_ram_raddr), 32'(b_rd_n % 4));
          chk_eq("b_re_avail", 32'(b_rd_n < b_wr_n), 32'd1);
        end
        if (qb.size() < 4) chk_eq("b_ready_hi", 32'(b_in_ready), 32'd1);
        if (qb.size() >= 6) begin
          chk_eq("b_ready_lo", 32'(b_in_ready), 32'd0);
          b_full_hits++;
        end
        if (qb.size() == 0) begin
          chk_eq("b_empty_valid", 32'(b_out_valid), 32'd0);
          chk_eq("b_empty_re", 32'(b_ram_re), 32'd0);
        end else if (b_out_valid) begin
          chk_eq("b_head", 32'(b_out_data), 32'(qb[0]));
          b_stall = 0;
        end else begin
          b_stall++;
          chk_eq("b_stall", 32'(b_stall <= 2), 32'd1);
        end
        if (b_out_valid && b_out_ready && qb.size() > 0) void'(qb.pop_front());
        if (b_in_valid && b_in_ready) begin
          qb.push_back(b_in_data); b_wr_n++; b_tot_wr++;
        end
        if (b_ram_re) b_rd_n++;
      end
    end
  end

  // Random driver for instance B, phases bias towards full, empty, balanced
  initial begin
    int cyc;
    int ph;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 8'd0;
    cyc = 0;
    while (!done) begin
      nxt();
      ph = (cyc / 300) % 3;
      b_in_valid  = pct(ph == 0 ? 85 : (ph == 1 ? 25 : 60));
      b_out_ready = pct(ph == 0 ? 25 : (ph == 1 ? 85 : 60));
      b_in_data   = 8'($urandom);
      cyc++;
    end
    b_in_valid = 1'b0;
  end

  task automatic drain_a(input string tag);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 600 && a_count != 10'd0; c++) nxt();
    chk_eq(tag, 32'(a_count), 32'd0);
    a_out_ready = 1'b0;
  endtask

  initial begin
    int k;
    int e;
    int ph;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 8'd0;
    reset_ = 1'b1;
    #2 reset_ = 1'b0;

    // Reset with a producer already asserting valid
    repeat (2) nxt();
    a_in_valid = 1'b1; a_in_data = 8'h77;
    @(negedge clk);
    chk_eq("t1_in_ready", 32'(a_in_ready), 32'd0);
    chk_eq("t1_ram_we", 32'(a_ram_we), 32'd0);
    chk_eq("t1_out_valid", 32'(a_out_valid), 32'd0);
    chk_eq("t1_count", 32'(a_count), 32'd0);
    nxt();
    a_in_valid = 1'b0; reset_ = 1'b1;
    @(negedge clk);
    chk_eq("t1_ready_after", 32'(a_in_ready), 32'd1);

    // Single entry latency
    nxt();
    a_in_valid = 1'b1; a_in_data = 8'hA5;
    @(negedge clk);
    chk_eq("t2_we0", 32'(a_ram_we), 32'd1);
    chk_eq("t2_waddr0", 32'(a_ram_waddr), 32'd0);
    nxt();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk_eq("t2_re1", 32'(a_ram_re), 32'd1);
    chk_eq("t2_raddr1", 32'(a_ram_raddr), 32'd0);
    chk_eq("t2_count1", 32'(a_count), 32'd1);
    nxt();
    @(negedge clk);
    chk_eq("t2_valid2", 32'(a_out_valid), 32'd0);
    chk_eq("t2_count2", 32'(a_count), 32'd1);
    nxt();
    @(negedge clk);
    chk_eq("t2_valid3", 32'(a_out_valid), 32'd1);
    chk_eq("t2_data3", 32'(a_out_data), 32'hA5);
    chk_eq("t2_count3", 32'(a_count), 32'd1);
    nxt();
    a_out_ready = 1'b1;
    @(negedge clk);
    chk_eq("t2_hold", 32'(a_out_data), 32'hA5);
    nxt();
    a_out_ready = 1'b0;
    @(negedge clk);
    chk_eq("t2_count_pop", 32'(a_count), 32'd0);
    chk_eq("t2_valid_pop", 32'(a_out_valid), 32'd0);

    // Fill to capacity with the consumer stalled, then drain in order
    nxt();
    k = 0;
    a_in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      a_in_data = 8'(k);
      @(negedge clk);
      if (a_in_ready) k++;
      nxt();
    end
    chk_eq("t3_accepted", 32'(k), 32'd258);
    @(negedge clk);
    chk_eq("t3_count_full", 32'(a_count), 32'd258);
    chk_eq("t3_ready_full", 32'(a_in_ready), 32'd0);
    chk_eq("t3_head", 32'(a_out_data), 32'd0);
    nxt();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    e = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a_count == 10'd0) break;
      if (a_out_valid) begin
        chk_eq("t3_order", 32'(a_out_data), 32'(e & 255));
        e++;
      end
      nxt();
    end
    chk_eq("t3_popped", 32'(e), 32'd258);
    chk_eq("t3_count_empty", 32'(a_count), 32'd0);
    nxt();
    a_out_ready = 1'b0;

    // Streaming: one write and one read every cycle
    nxt();
    k = 0; e = 0;
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      a_in_data = 8'(k);
      @(negedge clk);
      if (c >= 3) begin
        chk_eq("t4_count", 32'(a_count), 32'd3);
        chk_eq("t4_valid", 32'(a_out_valid), 32'd1);
      end
      if (a_in_ready) k++;
      if (a_out_valid) begin
        chk_eq("t4_order", 32'(a_out_data), 32'(e & 255));
        e++;
      end
      nxt();
    end
    chk_eq("t4_pops", 32'(e), 32'd997);
    drain_a("t4_drain");

    // Reset with five entries held and a read in flight
    nxt();
    a_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      a_in_data = 8'(8'h10 + c);
      nxt();
    end
    a_in_valid = 1'b0;
    repeat (4) nxt();
    a_in_valid = 1'b1; a_in_data = 8'h99; a_out_ready = 1'b1;
    nxt();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk_eq("t6_count_before", 32'(a_count), 32'd5);
    reset_ = 1'b0;
    #1;
    chk_eq("t6_count_rst", 32'(a_count), 32'd0);
    chk_eq("t6_valid_rst", 32'(a_out_valid), 32'd0);
    @(negedge clk);
    nxt();
    reset_ = 1'b1;
    nxt();
    a_in_valid = 1'b1; a_in_data = 8'h3C;
    @(negedge clk);
    chk_eq("t6_we", 32'(a_ram_we), 32'd1);
    chk_eq("t6_waddr", 32'(a_ram_waddr), 32'd0);
    nxt();
    a_in_valid = 1'b0;
    for (int c = 0; c < 10 && !a_out_valid; c++) nxt();
    chk_eq("t6_valid", 32'(a_out_valid), 32'd1);
    chk_eq("t6_data", 32'(a_out_data), 32'h3C);
    drain_a("t6_drain");

    // Randomized traffic, both instances checked by their models
    for (int c = 0; c < 24000; c++) begin
      ph = (c / 700) % 3;
      a_in_valid  = pct(ph == 0 ? 85 : (ph == 1 ? 25 : 60));
      a_out_ready = pct(ph == 0 ? 25 : (ph == 1 ? 85 : 60));
      a_in_data   = 8'($urandom);
      nxt();
    end
    done = 1'b1;
    drain_a("t5_drain");
    repeat (3) nxt();
    chk_eq("t5_a_wrapped", 32'(a_tot_wr > 1024), 32'd1);
    chk_eq("t5_b_wrapped", 32'(b_tot_wr > 64), 32'd1);
    chk_eq("t5_b_full_seen", 32'(b_full_hits > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
